// File: rtl/ucdp_evt_sched.sv
// Round-robin event scheduler: per-source pending bits offered one at a time
// over valid/ready, with sticky per-source overflow flags and saturating counters.
module ucdp_evt_sched #(
   parameter  int width_p = 4,
   parameter  int cntw_p  = 4,
   localparam int idxw    = (width_p > 1) ? $clog2(width_p) : 1
) (
   input  logic                      main_clk_i,
   input  logic                      main_rst_i,
   input  logic [width_p-1:0]        evt_i,
   input  logic [width_p-1:0]        en_i,
   input  logic                      clr_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [idxw-1:0]           idx_o,
   output logic [width_p-1:0]        ovf_o,
   output logic [width_p*cntw_p-1:0] ovf_cnt_o,
   output logic [0:0]                dbg_state_o
);

   localparam logic [0:0] st_idle  = 1'b0;
   localparam logic [0:0] st_offer = 1'b1;

   logic [0:0]         state_q;
   logic [width_p-1:0] pend_q;
   logic [width_p-1:0] ovf_q;
   logic [cntw_p-1:0]  cnt_q [width_p];
   logic [idxw-1:0]    idx_q;
   logic [idxw-1:0]    ptr_q;

   logic               valid_c;
   logic               hs_c;
   logic               found_c;
   logic [width_p-1:0] set_c;
   logic [width_p-1:0] hs_mask_c;
   logic [width_p-1:0] keep_c;
   logic [width_p-1:0] cand_c;
   logic [width_p-1:0] ovf_ev_c;
   logic [idxw-1:0]    nxt_c;
   logic [idxw-1:0]    start_c;
   logic [idxw-1:0]    win_c;

   // Handshake: valid_o/idx_o hold stable until ready_i is seen high while
   // valid_o is high; that cycle transfers exactly one event.
   assign valid_c = (state_q == st_offer);
   assign hs_c    = valid_c & ready_i;
   assign set_c   = evt_i & en_i;

   always_comb begin
      hs_mask_c = '0;
      keep_c    = en_i;
      if (valid_c) keep_c[idx_q] = 1'b1;
      if (hs_c) hs_mask_c[idx_q] = 1'b1;
   end

   // A new event on the source being accepted re-arms its pending bit.
   assign ovf_ev_c = set_c & pend_q & ~hs_mask_c;
   assign cand_c   = pend_q & keep_c & ~hs_mask_c;

   always_comb begin
      int n;
      n = int'(idx_q) + 1;
      if (n >= width_p) n = 0;
      nxt_c = idxw'(n);
   end

   // After a handshake the search resumes right after the granted index.
   assign start_c = hs_c ? nxt_c : ptr_q;

   always_comb begin
      int j;
      found_c = 1'b0;
      win_c   = '0;
      for (int k = 0; k < width_p; k++) begin
         j = int'(start_c) + k;
         if (j >= width_p) j = j - width_p;
         if (!found_c && cand_c[j]) begin
            found_c = 1'b1;
            win_c   = idxw'(j);
         end
      end
   end

   always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) begin
         state_q <= st_idle;
         pend_q  <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else begin
         pend_q <= (pend_q & ~hs_mask_c & keep_c) | set_c;
         if (hs_c) ptr_q <= nxt_c;
         case (state_q)
            st_idle: begin
               if (found_c) begin
                  state_q <= st_offer;
                  idx_q   <= win_c;
               end
            end
            default: begin
               if (hs_c) begin
                  if (found_c) idx_q <= win_c;
                  else         state_q <= st_idle;
               end
            end
         endcase
      end
   end

   // A fresh overflow outranks a simultaneous clear and restarts the count at 1.
   always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) begin
         ovf_q <= '0;
         for (int i = 0; i < width_p; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < width_p; i++) begin
            if (ovf_ev_c[i]) begin
               ovf_q[i] <= 1'b1;
               if (clr_i)                               cnt_q[i] <= cntw_p'(1);
               else if (cnt_q[i] != {cntw_p{1'b1}})     cnt_q[i] <= cnt_q[i] + cntw_p'(1);
            end else if (clr_i) begin
               ovf_q[i] <= 1'b0;
               cnt_q[i] <= '0;
            end
         end
      end
   end

   for (genvar g = 0; g < width_p; g++) begin : g_cnt
      assign ovf_cnt_o[g*cntw_p +: cntw_p] = cnt_q[g];
   end

   assign valid_o     = valid_c;
   assign idx_o       = idx_q;
   assign ovf_o       = ovf_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ucdp_evt_sched.sv
// Directed bench for ucdp_evt_sched (width_p = 4, cntw_p = 4) with
// hand-computed expectations for latency, round-robin order and overflow.
module tb_ucdp_evt_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  evt;
   logic [3:0]  en;
   logic        clr;
   logic        valid;
   logic        ready;
   logic [1:0]  idx;
   logic [3:0]  ovf;
   logic [15:0] ovf_cnt;
   logic [0:0]  dbg_state;

   int n_chk  = 0;
   int n_pass = 0;

   ucdp_evt_sched #(.width_p(4), .cntw_p(4)) dut (
      .main_clk_i (clk),
      .main_rst_i (rst),
      .evt_i      (evt),
      .en_i       (en),
      .clr_i      (clr),
      .valid_o    (valid),
      .ready_i    (ready),
      .idx_o      (idx),
      .ovf_o      (ovf),
      .ovf_cnt_o  (ovf_cnt),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      else n_pass++;
   endtask

   task automatic expect_offer(input string tag, input logic v, input int i);
      check({tag, ".valid"}, 32'(valid), 32'(v));
      check({tag, ".state"}, 32'(dbg_state), 32'(v));
      if (v) check({tag, ".idx"}, 32'(idx), 32'(i));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      evt = 4'b0000;
      en  = 4'b1111;
      clr = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      evt   = 4'b0000;
      en    = 4'b1111;
      clr   = 1'b0;
      ready = 1'b0;
      step();
      step();
      expect_offer("rst", 1'b0, 0);
      check("rst.idx", 32'(idx), 32'd0);
      check("rst.ovf", 32'(ovf), 32'd0);
      check("rst.cnt", 32'(ovf_cnt), 32'd0);

      // single event, first after reset release, latency 2
      rst = 1'b0; evt = 4'b0001; ready = 1'b1;
      step(); evt = 4'b0000;
      expect_offer("t1.c1", 1'b0, 0);
      step(); expect_offer("t1.c2", 1'b1, 0);
      step(); expect_offer("t1.c3", 1'b0, 0);
      step(); expect_offer("t1.c4", 1'b0, 0);

      // all four at once: back-to-back grants 0,1,2,3
      do_reset();
      evt = 4'b1111; ready = 1'b1;
      step(); evt = 4'b0000;
      expect_offer("t2.c1", 1'b0, 0);
      for (int k = 0; k < 4; k++) begin
         step(); expect_offer($sformatf("t2.g%0d", k), 1'b1, k);
      end
      step(); expect_offer("t2.end", 1'b0, 0);

      // pointer moved to 2 by granting 1, then pend 0101 -> 2 then 0
      do_reset();
      evt = 4'b0010; ready = 1'b1;
      step(); evt = 4'b0000;
      step(); expect_offer("t3.g1", 1'b1, 1);
      step(); expect_offer("t3.idle", 1'b0, 0);
      evt = 4'b0101; ready = 1'b0;
      step(); evt = 4'b0000;
      expect_offer("t3.pend", 1'b0, 0);
      step(); expect_offer("t3.g2", 1'b1, 2);
      step(); expect_offer("t3.hold", 1'b1, 2);
      ready = 1'b1;
      step(); expect_offer("t3.g0", 1'b1, 0);
      step(); expect_offer("t3.end", 1'b0, 0);

      // stalled offer, 20 repeat events on source 1 -> saturate at 15
      do_reset();
      ready = 1'b0; evt = 4'b0010;
      step(); evt = 4'b0000;
      step(); expect_offer("t4.offer", 1'b1, 1);
      for (int k = 0; k < 20; k++) begin
         evt = 4'b0010;
         step();
         expect_offer($sformatf("t4.p%0d", k), 1'b1, 1);
      end
      evt = 4'b0000;
      check("t4.ovf", 32'(ovf), 32'h2);
      check("t4.cnt", 32'(ovf_cnt), 32'h00F0);
      clr = 1'b1;
      step(); clr = 1'b0;
      check("t4.clr.ovf", 32'(ovf), 32'h0);
      check("t4.clr.cnt", 32'(ovf_cnt), 32'h0);
      clr = 1'b1; evt = 4'b0010;
      step(); clr = 1'b0; evt = 4'b0000;
      check("t4.prio.ovf", 32'(ovf), 32'h2);
      check("t4.prio.cnt", 32'(ovf_cnt), 32'h0010);
      ready = 1'b1;
      step(); expect_offer("t4.drain", 1'b0, 0);
      clr = 1'b1;
      step(); clr = 1'b0;
      check("t4.clr2.cnt", 32'(ovf_cnt), 32'h0);

      // event coincident with handshake of the same index is kept
      do_reset();
      evt = 4'b1000; ready = 1'b1;
      step(); evt = 4'b0000;
      step(); expect_offer("t5.g3", 1'b1, 3);
      evt = 4'b1000;
      step(); evt = 4'b0000;
      expect_offer("t5.idle", 1'b0, 0);
      check("t5.ovf0", 32'(ovf), 32'h0);
      step(); expect_offer("t5.g3b", 1'b1, 3);
      step(); expect_offer("t5.end", 1'b0, 0);
      check("t5.ovf1", 32'(ovf), 32'h0);

      // enable masking: disabled events ignored, disabled pending dropped
      do_reset();
      ready = 1'b0; evt = 4'b0001; en = 4'b1110;
      step(); evt = 4'b0000;
      step(); expect_offer("t6.masked", 1'b0, 0);
      evt = 4'b0011; en = 4'b1111;
      step(); evt = 4'b0000;
      step(); expect_offer("t6.g0", 1'b1, 0);
      en = 4'b1100;
      step(); en = 4'b1111;
      expect_offer("t6.keep", 1'b1, 0);
      ready = 1'b1;
      step(); expect_offer("t6.drop", 1'b0, 0);
      step(); expect_offer("t6.end", 1'b0, 0);

      // asynchronous reset mid-offer discards pending events
      do_reset();
      ready = 1'b0; evt = 4'b1110;
      step(); evt = 4'b0000;
      step(); expect_offer("t7.g1", 1'b1, 1);
      #2 rst = 1'b1;
      #1 expect_offer("t7.async", 1'b0, 0);
      step(); rst = 1'b0; ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(); expect_offer($sformatf("t7.empty%0d", k), 1'b0, 0);
      end
      evt = 4'b0100;
      step(); evt = 4'b0000;
      step(); expect_offer("t7.g2", 1'b1, 2);
      step(); expect_offer("t7.end", 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ucdp_evt_sched.md
UCDP_EVT_SCHED -- requirements
Module: ucdp_evt_sched

Interface
REQ-001 SHALL have parameter width_p, default 4, meaning number of event sources, legal range 1..16.
REQ-002 SHALL have parameter cntw_p, default 4, meaning width of the per-source saturating overflow counter, legal range 1..8.
REQ-003 SHALL have port main_clk_i, input, 1 bit, the single clock; all flops on its rising edge.
REQ-004 SHALL have port main_rst_i, input, 1 bit, reset, asynchronous assert, active-high.
REQ-005 SHALL have port evt_i, input, width_p bits, one-cycle event pulses per source, already synchronized to main_clk_i (edge outputs of sync cells).
REQ-006 SHALL have port en_i, input, width_p bits, per-source enable.
REQ-007 SHALL have port clr_i, input, 1 bit, synchronous clear of all overflow flags and counters.
REQ-008 SHALL have port valid_o, output, 1 bit, event offer valid.
REQ-009 SHALL have port ready_i, input, 1 bit, consumer accepts the offer.
REQ-010 SHALL have port idx_o, output, idxw bits with idxw = max(1, ceil(log2(width_p))), the source index of the offer.
REQ-011 SHALL have port ovf_o, output, width_p bits, sticky per-source overflow flags.
REQ-012 SHALL have port ovf_cnt_o, output, width_p*cntw_p bits, per-source overflow counters; source i occupies bits [i*cntw_p +: cntw_p].

Function
REQ-013 SHALL keep one pending bit per source; evt_i[i] & en_i[i] sets pend[i] at the next edge.
REQ-014 SHALL clear pend[i] at the next edge when en_i[i] = 0, except for the source currently offered.
REQ-015 SHALL implement a two-state FSM: IDLE (valid_o = 0) and OFFER (valid_o = 1); valid_o and idx_o are registered outputs.
REQ-016 IDLE -> OFFER SHALL occur when any pend bit is set; the winner is loaded into idx_o, and valid_o rises one cycle after pend is visible (latency evt_i -> valid_o = 2 cycles).
REQ-017 In OFFER with ready_i = 0, valid_o and idx_o SHALL hold stable; no re-arbitration takes place.
REQ-018 On handshake (valid_o & ready_i), pend[idx_o] SHALL clear; if further pend bits remain (excluding idx_o), the next winner SHALL load at the same edge and the FSM stays in OFFER (throughput 1 event/cycle); otherwise the FSM goes to IDLE.
REQ-019 Arbitration SHALL be round-robin: search starts at last granted index + 1, modulo width_p; after reset the search starts at index 0.
REQ-020 The pointer SHALL update only on handshake.
REQ-021 Handshake on source i in the same cycle as evt_i[i] & en_i[i] SHALL leave pend[i] set (the new event is kept); this is not an overflow.
REQ-022 evt_i[i] & en_i[i] while pend[i] = 1 and pend[i] is not being cleared by a handshake that cycle SHALL set ovf_o[i] and increment counter i, saturating at 2^cntw_p-1.
REQ-023 clr_i SHALL zero all ovf_o and counters; an overflow in the same cycle as clr_i SHALL take priority and leave flag = 1, count = 1.
REQ-024 When width_p = 1, idx_o SHALL be constant 0 and the arbiter degenerates to a single pending bit.

Reset
REQ-025 While main_rst_i = 1: pend = 0, FSM = IDLE, valid_o = 0, idx_o = 0, pointer = 0, ovf_o = 0, ovf_cnt_o = 0.
REQ-026 Reset asserted mid-offer SHALL drop valid_o immediately (asynchronously) and discard all pending events.
REQ-027 The first evt_i sampled after reset release SHALL be captured.

Verification
REQ-028 Pulse evt_i = 4'b0001 in cycle 0 with ready_i = 1 -> valid_o = 1 and idx_o = 0 in cycle 2 only; pend empty afterwards.
REQ-029 evt_i = 4'b1111 in one cycle, ready_i = 1 -> idx_o = 0, 1, 2, 3 on consecutive cycles; valid_o is continuous for 4 cycles.
REQ-030 Pointer at 2, pend = 4'b0101 -> grants 2, then 0.
REQ-031 ready_i = 0 held while evt_i[1] pulses 20 times -> idx_o = 1 held stable, ovf_o[1] = 1, counter 1 = 15 (saturated at cntw_p = 4); clr_i -> 0.
REQ-032 evt_i[3] coincident with handshake of index 3 -> pend[3] remains set, index 3 is offered again later, ovf_o[3] = 0.
REQ-033 Assert main_rst_i during OFFER with pend = 4'b1110 -> valid_o = 0 without a clock edge; nothing is offered after release until a new event arrives.
